// File: rtl/crypto_instr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crypto_instr_pkg
// Description : Shared types, widths and helpers for the crypto functional
//               unit, including the SM3 permutation arbiter entry format.
// Revision    : 1.0 - initial release
// ============================================================================
package crypto_instr_pkg;

    // Datapath width of the crypto functional unit (32 or 64)
    localparam int unsigned XLEN = 64;

    // Default tag widths for one queued SM3 arbiter result
    localparam int unsigned SM3_ARB_TRANS_ID_BITS = 3;
    localparam int unsigned SM3_ARB_REQ_ID_BITS   = 1;

    typedef enum logic {
        SM3_P0 = 1'b0,
        SM3_P1 = 1'b1
    } sm3_op_e;

    typedef struct packed {
        logic [XLEN-1:0]                  data;
        logic [SM3_ARB_TRANS_ID_BITS-1:0] trans_id;
        logic [SM3_ARB_REQ_ID_BITS-1:0]   req_id;
    } sm3_arb_entry_t;

    // 32-bit rotate left; n is expected in 0..31
    function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/crypto_sm3.sv
`default_nettype none
// ============================================================================
// Module      : crypto_sm3
// Description : Combinational SM3 P0/P1 permutation on a 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module crypto_sm3
    import crypto_instr_pkg::*;
(
    input  sm3_op_e     i_op,
    input  logic [31:0] i_rs1,
    output logic [31:0] o_result
);

    // Select P0 or P1 linear permutation of the operand
    always_comb begin
        o_result = i_rs1 ^ rol32(i_rs1, 9) ^ rol32(i_rs1, 17);
        if (i_op == SM3_P1) begin
            o_result = i_rs1 ^ rol32(i_rs1, 15) ^ rol32(i_rs1, 23);
        end
    end

endmodule
`default_nettype wire

// File: rtl/crypto_sm3_arb.sv
`default_nettype none
// ============================================================================
// Module      : crypto_sm3_arb
// Description : Round-robin arbiter sharing one SM3 P0/P1 unit between
//               NUM_REQ requesters, with an in-order output FIFO carrying
//               trans_id and requester tag. Flush discards all queued work.
//               Optional macro CRYPTO_SM3_ARB_PERF_EN adds perf_ops_o and
//               perf_stall_o event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module crypto_sm3_arb
    import crypto_instr_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    flush_i,
    input  logic [NUM_REQ-1:0]                      req_valid_i,
    output logic [NUM_REQ-1:0]                      req_ready_o,
    input  logic [NUM_REQ-1:0]                      req_op_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]            req_rs1_i,
    input  logic [NUM_REQ-1:0][TRANS_ID_BITS-1:0]   req_trans_id_i,
    output logic                                    res_valid_o,
    input  logic                                    res_ready_i,
    output logic [XLEN-1:0]                         res_data_o,
    output logic [TRANS_ID_BITS-1:0]                res_trans_id_o,
    output logic [$clog2(NUM_REQ)-1:0]              res_req_id_o
`ifdef CRYPTO_SM3_ARB_PERF_EN
    ,
    output logic [31:0]                             perf_ops_o,
    output logic [31:0]                             perf_stall_o
`endif
);

    localparam int unsigned c_ID_W  = $clog2(NUM_REQ);
    localparam int unsigned c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0]          data;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [c_ID_W-1:0]        req_id;
    } entry_t;

    // Returns {found, index} of the first valid requester at or after ptr
    function automatic logic [c_ID_W:0] f_rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [c_ID_W-1:0]  ptr
    );
        logic              found;
        logic [c_ID_W-1:0] idx;
        logic [c_ID_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = c_ID_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_ID_W-1:0]  r_rr_ptr;
    entry_t             r_mem [FIFO_DEPTH];

    logic [c_ID_W:0]    w_pick;
    logic [c_ID_W-1:0]  w_grant_id;
    logic               w_space;
    logic               w_accept;
    logic               w_pop;
    sm3_op_e            w_sm3_op;
    logic [31:0]        w_sm3_rs1;
    logic [31:0]        w_sm3_res;
    logic [XLEN-1:0]    w_push_data;
    entry_t             w_push_entry;
    entry_t             w_head;
    logic               w_unused_rs1;

    // Grant at most one requester; a full FIFO blocks grants so that
    // res_ready_i never reaches the ready path
    always_comb begin
        w_pick      = f_rr_pick(req_valid_i, r_rr_ptr);
        w_grant_id  = w_pick[c_ID_W-1:0];
        w_space     = (r_count < c_CNT_W'(FIFO_DEPTH));
        w_accept    = w_pick[c_ID_W] & w_space & ~flush_i & ~rst_i;
        req_ready_o = '0;
        if (w_accept) begin
            req_ready_o[w_grant_id] = 1'b1;
        end
    end

    assign w_sm3_op  = sm3_op_e'(req_op_i[w_grant_id]);
    assign w_sm3_rs1 = req_rs1_i[w_grant_id][31:0];

    // Only the low word of each operand feeds the permutation
    assign w_unused_rs1 = ^req_rs1_i;

    crypto_sm3 u_sm3 (
        .i_op     (w_sm3_op),
        .i_rs1    (w_sm3_rs1),
        .o_result (w_sm3_res)
    );

    generate
        if (XLEN > 32) begin : g_sext
            assign w_push_data = {{(XLEN-32){w_sm3_res[31]}}, w_sm3_res};
        end else begin : g_nosext
            assign w_push_data = w_sm3_res;
        end
    endgenerate

    assign w_push_entry = '{data: w_push_data,
                            trans_id: req_trans_id_i[w_grant_id],
                            req_id: w_grant_id};

    assign w_head         = r_mem[r_rd_ptr];
    assign res_valid_o    = (r_count != '0);
    assign res_data_o     = w_head.data;
    assign res_trans_id_o = w_head.trans_id;
    assign res_req_id_o   = w_head.req_id;
    assign w_pop          = res_valid_o & res_ready_i;

    // FIFO storage, pointers, occupancy and round-robin pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rr_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_push_entry;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
                r_rr_ptr        <= (w_grant_id == c_ID_W'(NUM_REQ - 1)) ?
                                   '0 : (w_grant_id + c_ID_W'(1));
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

`ifdef CRYPTO_SM3_ARB_PERF_EN
    logic [31:0] r_perf_ops;
    logic [31:0] r_perf_stall;

    // Event counters survive flush; only reset clears them
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_ops   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept) begin
                r_perf_ops <= r_perf_ops + 32'd1;
            end
            if ((|req_valid_i) && !w_accept) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_ops_o   = r_perf_ops;
    assign perf_stall_o = r_perf_stall;
`endif

endmodule
`default_nettype wire
